// File: rtl/orange_sweep_ctrl_pkg.sv
// Shared types and sizes for the Orange_a built-in self-test sweep controller.
package orange_pkg;

   localparam int VEC_W = 4;
   localparam int N_VEC = 16;
   localparam int CNT_W = 5;

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      HOLD   = 5'b00010,
      SAMPLE = 5'b00100,
      CHECK  = 5'b01000,
      DONE   = 5'b10000
   } state_t;

endpackage

// File: rtl/orange_sweep_ctrl_if.sv
// Control/result bundle between the sweep controller and its host plus the Orange_a under test.
interface orange_sweep_ctrl_if;
   import orange_pkg::*;

   logic             start;
   logic [N_VEC-1:0] expected;
   logic             y;
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             busy;
   logic             done;
   logic [N_VEC-1:0] table_q;
   logic             pass;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [VEC_W-1:0] first_fail;

   modport master (
      output start, expected, y,
      input  a, b, c, d, busy, done, table_q, pass, mismatch_cnt, first_fail
   );

   modport slave (
      input  start, expected, y,
      output a, b, c, d, busy, done, table_q, pass, mismatch_cnt, first_fail
   );

endinterface

// File: rtl/orange_sweep_ctrl_fail_scan.sv
// Combinational scan of a truth-table diff: number of differing bits and lowest differing index.
module orange_fail_scan
   import orange_pkg::*;
(
   input  logic [N_VEC-1:0] i_diff,
   output logic [CNT_W-1:0] o_popcnt,
   output logic [VEC_W-1:0] o_lowest
);

   // Walk from the top bit down so the last hit recorded is the lowest one.
   always_comb begin
      o_popcnt = '0;
      o_lowest = '0;
      for (int i = N_VEC - 1; i >= 0; i--) begin
         o_popcnt = o_popcnt + CNT_W'(i_diff[i]);
         o_lowest = i_diff[i] ? VEC_W'(i) : o_lowest;
      end
   end

endmodule

// File: rtl/orange_sweep_ctrl.sv
// Exhaustive 16-vector sweep of Orange_a: hold each vector, sample y, then compare against a golden table.
module orange_sweep_ctrl
   import orange_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)
(
   input  logic                clk,
   input  logic                rst,
   orange_sweep_ctrl_if.slave  bus
);

   localparam logic [VEC_W-1:0] SETTLE_V = SETTLE_CYCLES[VEC_W-1:0];
   localparam logic [VEC_W-1:0] LAST_IDX = 4'd15;

   state_t           r_state;
   logic [VEC_W-1:0] r_idx;
   logic [VEC_W-1:0] r_settle;
   logic [N_VEC-1:0] r_expected;
   logic [N_VEC-1:0] r_table;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_mm;
   logic [VEC_W-1:0] r_ff;

   logic [N_VEC-1:0] w_diff;
   logic [CNT_W-1:0] w_popcnt;
   logic [VEC_W-1:0] w_lowest;

   assign w_diff = r_table ^ r_expected;

   orange_fail_scan u_fail_scan (
      .i_diff   (w_diff),
      .o_popcnt (w_popcnt),
      .o_lowest (w_lowest)
   );

   // Sweep sequencer; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_settle   <= '0;
         r_expected <= '0;
         r_table    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mm       <= '0;
         r_ff       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_expected <= bus.expected;
                  r_table    <= '0;
                  r_pass     <= 1'b0;
                  r_mm       <= '0;
                  r_ff       <= '0;
                  r_idx      <= '0;
                  r_settle   <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= HOLD;
               end else begin
                  r_state <= IDLE;
               end
            end
            HOLD: begin
               if (r_settle == SETTLE_V) begin
                  r_state <= SAMPLE;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            SAMPLE: begin
               r_table[r_idx] <= bus.y;
               // Termination is decided here so the 4-bit index never wraps.
               if (r_idx == LAST_IDX) begin
                  r_busy  <= 1'b0;
                  r_state <= CHECK;
               end else begin
                  r_idx    <= r_idx + 4'd1;
                  r_settle <= '0;
                  r_state  <= HOLD;
               end
            end
            CHECK: begin
               r_pass  <= (w_diff == '0);
               r_mm    <= w_popcnt;
               r_ff    <= w_lowest;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_idx   <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_idx   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.a            = r_idx[3];
   assign bus.b            = r_idx[2];
   assign bus.c            = r_idx[1];
   assign bus.d            = r_idx[0];
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.table_q      = r_table;
   assign bus.pass         = r_pass;
   assign bus.mismatch_cnt = r_mm;
   assign bus.first_fail   = r_ff;

endmodule

// File: tb/tb_orange_sweep_ctrl.sv
// Directed bench for orange_sweep_ctrl: default-settle and zero-settle instances with a modelled Orange_a.
module tb_orange_sweep_ctrl;
   import orange_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   mode  = 0;

   orange_sweep_ctrl_if if_a ();
   orange_sweep_ctrl_if if_z ();

   orange_sweep_ctrl u_dut (.clk(clk), .rst(rst), .bus(if_a));
   orange_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if_z));

   always #5 clk = ~clk;

   // Orange_a stand-in: 0 -> d, 1 -> a, 2 -> ~d, 3 -> b&c; v = {a,b,c,d}
   function automatic logic fy(input int m, input logic [3:0] v);
      case (m)
         0:       return v[0];
         1:       return v[3];
         2:       return ~v[0];
         3:       return v[2] & v[1];
         default: return 1'b0;
      endcase
   endfunction

   always_comb if_a.y = fy(mode, {if_a.a, if_a.b, if_a.c, if_a.d});
   always_comb if_z.y = fy(mode, {if_z.a, if_z.b, if_z.c, if_z.d});

   // Pulse start from an IDLE cycle; lat / v5 are the k+n cycle of done / first vector 5 (-1 = never).
   task automatic do_sweep(input bit use_z, output int lat, output int v5);
      logic [3:0] vec;
      logic       dn;
      repeat (2) @(negedge clk);
      if (use_z) if_z.start = 1'b1; else if_a.start = 1'b1;
      @(posedge clk); #1;
      if_a.start = 1'b0;
      if_z.start = 1'b0;
      lat = -1;
      v5  = -1;
      for (int n = 1; n <= 200; n++) begin
         if (n > 1) begin @(posedge clk); #1; end
         vec = use_z ? {if_z.a, if_z.b, if_z.c, if_z.d} : {if_a.a, if_a.b, if_a.c, if_a.d};
         dn  = use_z ? if_z.done : if_a.done;
         if (vec == 4'd5 && v5 < 0) v5 = n;
         if (dn) begin lat = n; break; end
      end
   endtask

   task automatic test_reset();
      if_a.start = 1'b0; if_z.start = 1'b0;
      if_a.expected = 16'h0000; if_z.expected = 16'h0000;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if ({if_a.a, if_a.b, if_a.c, if_a.d, if_a.busy, if_a.done} !== 6'b000000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 000000", {if_a.a, if_a.b, if_a.c, if_a.d, if_a.busy, if_a.done});
      end
      total++; if ({if_a.table_q, if_a.pass, if_a.mismatch_cnt, if_a.first_fail} !== 26'h0) begin
         bad++; $display("FAIL reset_results: got %h want 0", {if_a.table_q, if_a.pass, if_a.mismatch_cnt, if_a.first_fail});
      end
      total++; if ({if_z.busy, if_z.done, if_z.table_q} !== 18'h0) begin
         bad++; $display("FAIL reset_z: got %h want 0", {if_z.busy, if_z.done, if_z.table_q});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_match();
      int lat, v5;
      mode = 0; if_a.expected = 16'hAAAA;
      do_sweep(1'b0, lat, v5);
      total++; if (lat !== 66) begin bad++; $display("FAIL match_latency: got %0d want 66", lat); end
      total++; if (v5 !== 21) begin bad++; $display("FAIL match_vec5_cycle: got %0d want 21", v5); end
      total++; if (if_a.table_q !== 16'hAAAA) begin bad++; $display("FAIL match_table: got %h want aaaa", if_a.table_q); end
      total++; if ({if_a.pass, if_a.mismatch_cnt, if_a.first_fail} !== {1'b1, 5'd0, 4'd0}) begin
         bad++; $display("FAIL match_result: got pass=%b mm=%0d ff=%0d want 1 0 0", if_a.pass, if_a.mismatch_cnt, if_a.first_fail);
      end
      total++; if ({if_a.busy, if_a.a, if_a.b, if_a.c, if_a.d} !== 5'b01111) begin
         bad++; $display("FAIL match_done_drive: got %b want 01111", {if_a.busy, if_a.a, if_a.b, if_a.c, if_a.d});
      end
      @(posedge clk); #1;
      total++; if ({if_a.done, if_a.a, if_a.b, if_a.c, if_a.d, if_a.table_q, if_a.pass} !== {5'b00000, 16'hAAAA, 1'b1}) begin
         bad++; $display("FAIL match_hold: got done=%b vec=%b tbl=%h pass=%b", if_a.done, {if_a.a, if_a.b, if_a.c, if_a.d}, if_a.table_q, if_a.pass);
      end
   endtask

   task automatic test_single_miss();
      int lat, v5;
      mode = 1; if_a.expected = 16'hFF01;
      do_sweep(1'b0, lat, v5);
      total++; if (if_a.table_q !== 16'hFF00) begin bad++; $display("FAIL single_table: got %h want ff00", if_a.table_q); end
      total++; if ({if_a.pass, if_a.mismatch_cnt, if_a.first_fail} !== {1'b0, 5'd1, 4'd0}) begin
         bad++; $display("FAIL single_result: got pass=%b mm=%0d ff=%0d want 0 1 0", if_a.pass, if_a.mismatch_cnt, if_a.first_fail);
      end
   endtask

   task automatic test_all_miss();
      int lat, v5;
      mode = 2; if_a.expected = 16'hAAAA;
      do_sweep(1'b0, lat, v5);
      total++; if (if_a.table_q !== 16'h5555) begin bad++; $display("FAIL allmiss_table: got %h want 5555", if_a.table_q); end
      total++; if ({if_a.pass, if_a.mismatch_cnt, if_a.first_fail} !== {1'b0, 5'd16, 4'd0}) begin
         bad++; $display("FAIL allmiss_result: got pass=%b mm=%0d ff=%0d want 0 16 0", if_a.pass, if_a.mismatch_cnt, if_a.first_fail);
      end
   endtask

   task automatic test_settle0();
      int lat, v5;
      mode = 3; if_z.expected = 16'h4040;
      do_sweep(1'b1, lat, v5);
      total++; if (lat !== 34) begin bad++; $display("FAIL settle0_latency: got %0d want 34", lat); end
      total++; if (v5 !== 11) begin bad++; $display("FAIL settle0_vec5_cycle: got %0d want 11", v5); end
      total++; if (if_z.table_q !== 16'hC0C0) begin bad++; $display("FAIL settle0_table: got %h want c0c0", if_z.table_q); end
      total++; if ({if_z.pass, if_z.mismatch_cnt, if_z.first_fail} !== {1'b0, 5'd2, 4'd7}) begin
         bad++; $display("FAIL settle0_result: got pass=%b mm=%0d ff=%0d want 0 2 7", if_z.pass, if_z.mismatch_cnt, if_z.first_fail);
      end
   endtask

   task automatic test_abort();
      int n9, dones, busys, lat, v5;
      mode = 0; if_a.expected = 16'hAAAA;
      repeat (2) @(negedge clk);
      if_a.start = 1'b1;
      @(posedge clk); #1;
      if_a.start = 1'b0;
      n9 = -1;
      for (int n = 1; n <= 200; n++) begin
         if (n > 1) begin @(posedge clk); #1; end
         if_a.start = (n == 3);
         if ({if_a.a, if_a.b, if_a.c, if_a.d} == 4'd9) begin n9 = n; break; end
      end
      if_a.start = 1'b0;
      total++; if (n9 !== 37) begin bad++; $display("FAIL abort_ignore_start: vec9 at %0d want 37", n9); end
      total++; if (if_a.table_q !== 16'h00AA) begin bad++; $display("FAIL abort_partial: got %h want 00aa", if_a.table_q); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      total++; if ({if_a.a, if_a.b, if_a.c, if_a.d, if_a.busy, if_a.done, if_a.table_q, if_a.pass, if_a.mismatch_cnt, if_a.first_fail} !== 32'h0) begin
         bad++; $display("FAIL abort_reset: got busy=%b tbl=%h vec=%b want all 0", if_a.busy, if_a.table_q, {if_a.a, if_a.b, if_a.c, if_a.d});
      end
      @(negedge clk); rst = 1'b0;
      dones = 0; busys = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (if_a.done) dones++;
         if (if_a.busy) busys++;
      end
      total++; if ({dones, busys} !== {32'd0, 32'd0}) begin bad++; $display("FAIL abort_quiet: done=%0d busy=%0d want 0 0", dones, busys); end
      do_sweep(1'b0, lat, v5);
      total++; if ({lat, 16'(if_a.table_q), 1'(if_a.pass)} !== {32'd66, 16'hAAAA, 1'b1}) begin
         bad++; $display("FAIL abort_fresh: lat=%0d tbl=%h pass=%b want 66 aaaa 1", lat, if_a.table_q, if_a.pass);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      mode = 0; if_a.expected = 16'hAAAA;
      repeat (2) @(negedge clk);
      if_a.start = 1'b1;
      @(posedge clk); #1;
      lat1 = -1;
      for (int n = 1; n <= 200; n++) begin
         if (n > 1) begin @(posedge clk); #1; end
         if (if_a.done) begin lat1 = n; break; end
      end
      total++; if (lat1 !== 66) begin bad++; $display("FAIL b2b_first_latency: got %0d want 66", lat1); end
      @(posedge clk); #1;
      total++; if ({if_a.busy, if_a.done, if_a.table_q} !== {2'b00, 16'hAAAA}) begin
         bad++; $display("FAIL b2b_idle_gap: busy=%b done=%b tbl=%h want 0 0 aaaa", if_a.busy, if_a.done, if_a.table_q);
      end
      @(posedge clk); #1;
      total++; if ({if_a.busy, if_a.table_q, if_a.a, if_a.b, if_a.c, if_a.d} !== {1'b1, 16'h0000, 4'b0000}) begin
         bad++; $display("FAIL b2b_restart: busy=%b tbl=%h want 1 0000", if_a.busy, if_a.table_q);
      end
      lat2 = -1;
      for (int n = 1; n <= 200; n++) begin
         if (n > 1) begin @(posedge clk); #1; end
         if (if_a.done) begin lat2 = n; break; end
      end
      if_a.start = 1'b0;
      total++; if ({lat2, 16'(if_a.table_q)} !== {32'd66, 16'hAAAA}) begin
         bad++; $display("FAIL b2b_second: lat=%0d tbl=%h want 66 aaaa", lat2, if_a.table_q);
      end
      repeat (3) @(posedge clk);
      #1;
      total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: busy=%b want 0", if_a.busy); end
   endtask

   initial begin
      test_reset();
      test_match();
      test_single_miss();
      test_all_miss();
      test_settle0();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/orange_sweep_ctrl.md
# orange_sweep_ctrl

Sequencer that exhaustively exercises the 4-input combinational `Orange_a` datapath in hardware. On `start` it steps `{a,b,c,d}` through all 16 input combinations in ascending binary order, waits a programmable settle time per vector, and samples `y`. It assembles the 16-bit truth table, compares it against an expected table, and reports pass/fail, mismatch count and first failing index. It sits beside an `Orange_a` instance as a built-in self-test controller.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before `y` is sampled; legal range 0..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; accepted only in IDLE.
- `expected` in 16: golden truth table; bit i is the expected `y` for vector i. Latched on start acceptance.
- `y` in 1: output of the `Orange_a` under control.
- `a`, `b`, `c`, `d` out 1 each: registered drive to `Orange_a`; `{a,b,c,d}` equals the current vector index, with `a` as MSB.
- `busy` out 1: high from the cycle after start acceptance until the last sample.
- `done` out 1: one-cycle pulse after the sweep completes.
- `table_q` out 16: captured truth table; bit i is the sampled `y` for vector i.
- `pass` out 1: `table_q == expected` as latched; valid from the `done` cycle onward.
- `mismatch_cnt` out 5: number of differing bits, 0..16.
- `first_fail` out 4: lowest differing index; 0 when `pass` is 1.

## Operation
- FSM states, each one-hot in the shared package:
  - IDLE: on `start`, latch `expected`, clear `table_q`, set index 0 and settle counter 0, go to HOLD.
  - HOLD: drive the index; increment the settle counter. At `SETTLE_CYCLES`, go to SAMPLE. With `SETTLE_CYCLES`=0, HOLD lasts 1 cycle.
  - SAMPLE: on this edge write `table_q[idx] <= y`. If idx==15, go to CHECK; else increment idx, clear the settle counter, go to HOLD.
  - CHECK: compute `pass`, `mismatch_cnt` and `first_fail` from `table_q ^ expected_q`; go to DONE.
  - DONE: assert `done` for one cycle; go to IDLE.
- `start` in any state other than IDLE is ignored; it is neither queued nor restarts the sweep.
- Results (`table_q`, `pass`, `mismatch_cnt`, `first_fail`) hold until the next accepted start, which clears them to 0.
- The index is 4 bits and never wraps mid-sweep. Termination is decided on idx==15 in SAMPLE.
- `mismatch_cnt` is a 5-bit popcount, so 16 differing bits is representable.

## Timing
- Reset values: all outputs 0, state IDLE, index 0.
- `rst` mid-sweep: next cycle is IDLE with all outputs 0. No `done` is issued and partial results are discarded.
- Start is accepted at edge k. `{a,b,c,d}`=0 and `busy`=1 from cycle k+1.
- Each vector occupies `SETTLE_CYCLES`+2 cycles: (`SETTLE_CYCLES`+1) in HOLD, then 1 in SAMPLE. `y` is therefore stable for at least `SETTLE_CYCLES`+1 cycles before capture.
- Sweep length is 16·(`SETTLE_CYCLES`+2) cycles. CHECK follows, then `done`. With the default, `done` is high in cycle k+66.
- `busy` drops in the CHECK cycle. Outputs `a..d` hold vector 15 until IDLE, then return to 0.
- `start` asserted in the `done` cycle is ignored. The earliest new sweep begins with start in the following IDLE cycle.

## Structure
- Package `orange_pkg` holds:
  - the `state_t` enum (IDLE, HOLD, SAMPLE, CHECK, DONE);
  - `VEC_W`=4 and `N_VEC`=16;
  - `CNT_W`=5 for the mismatch count.
- One natural sub-module, `orange_fail_scan`: purely combinational. From a 16-bit diff vector it produces the popcount and the lowest-set-bit index. It is registered in CHECK.
- `Orange_a` is instantiated by the parent, not inside this block.

## Test plan
- `y` tied to `d`, `expected`=16'hAAAA, default parameters → `table_q`=16'hAAAA, `pass`=1, `mismatch_cnt`=0, `first_fail`=0, `done` in cycle k+66.
- `y` tied to `a`, `expected`=16'hFF01 → `table_q`=16'hFF00, `pass`=0, `mismatch_cnt`=1, `first_fail`=0.
- `y` = ~d, `expected`=16'hAAAA → `mismatch_cnt`=16, `first_fail`=0, `pass`=0.
- `SETTLE_CYCLES`=0: `y` = `b`&`c`, `expected`=16'h4040 →
  - vectors change every 2 cycles, `done` in cycle k+34;
  - `table_q`=16'hC0C0, `mismatch_cnt`=2, `first_fail`=7.
- Second `start` pulsed while `busy`, then `rst` asserted at vector 9 →
  - the second start is ignored;
  - after reset all outputs are 0 and no `done` is issued;
  - a fresh sweep afterwards completes normally.
- Back-to-back sweeps: `start` held high continuously →
  - sweeps are separated by the DONE and IDLE cycles;
  - `table_q` clears at each acceptance.
